// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles the fetch stage's pipeline-facing and imem-facing signals.
//
//   master modport (used by fetch_stage):
//     in : stall, redirect, target_pc, q_imem
//     out: address_imem, pc, fd_instr, fd_pc, fd_pc_plus_one, fd_valid
//          perf_fetched, perf_bubbles (only when FETCH_PERF_EN is defined)
//   slave modport (used by the surrounding pipeline / imem): the reverse.
//
//   Optional feature macro: FETCH_PERF_EN (adds the performance counters).
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int ADDR_W = 12
);
  logic              stall;
  logic              redirect;
  logic [31:0]       target_pc;
  logic [31:0]       q_imem;
  logic [ADDR_W-1:0] address_imem;
  logic [31:0]       pc;
  logic [31:0]       fd_instr;
  logic [31:0]       fd_pc;
  logic [31:0]       fd_pc_plus_one;
  logic              fd_valid;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_bubbles;
`endif

  modport master (
    input  stall, redirect, target_pc, q_imem,
    output address_imem, pc, fd_instr, fd_pc, fd_pc_plus_one, fd_valid
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_bubbles
`endif
  );

  modport slave (
    output stall, redirect, target_pc, q_imem,
    input  address_imem, pc, fd_instr, fd_pc, fd_pc_plus_one, fd_valid
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_bubbles
`endif
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch front end feeding decode. Owns the word-addressed PC,
//   drives the synchronous imem (clocked on the inverted clock, so q_imem for
//   the current address is ready before the next rising edge) and captures
//   the returned word into the F/D register. Decode stalls hold everything;
//   execute redirects reload the PC and insert a bubble (redirect > stall).
//
//   Ports:
//     clock : rising-edge master clock
//     reset : synchronous, active-low reset
//     bus   : fetch_stage_if.master (stall, redirect, target_pc, q_imem in;
//             address_imem, pc, fd_instr, fd_pc, fd_pc_plus_one, fd_valid out;
//             perf_fetched, perf_bubbles out when FETCH_PERF_EN is defined)
//
//   Optional feature macro: FETCH_PERF_EN -- fetched/bubble event counters.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_pc_plus_one_q, fd_pc_plus_one_d;
  logic        fd_valid_q, fd_valid_d;

  // Next-state selection: redirect beats stall beats a normal advance.
  always_comb begin
    pc_d             = pc_q;
    fd_instr_d       = fd_instr_q;
    fd_pc_d          = fd_pc_q;
    fd_pc_plus_one_d = fd_pc_plus_one_q;
    fd_valid_d       = fd_valid_q;
    if (bus.redirect) begin
      // Wrong-path word currently on q_imem is dropped; a bubble goes to decode.
      pc_d             = bus.target_pc;
      fd_instr_d       = NOP_INSTR;
      fd_pc_d          = 32'd0;
      fd_pc_plus_one_d = 32'd0;
      fd_valid_d       = 1'b0;
    end else if (!bus.stall) begin
      pc_d             = pc_q + 32'd1;
      fd_instr_d       = bus.q_imem;
      fd_pc_d          = pc_q;
      fd_pc_plus_one_d = pc_q + 32'd1;
      fd_valid_d       = 1'b1;
    end
    // On stall the PC holds, so address_imem and q_imem stay put: no skid needed.
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q             <= RESET_PC;
      fd_instr_q       <= NOP_INSTR;
      fd_pc_q          <= 32'd0;
      fd_pc_plus_one_q <= 32'd0;
      fd_valid_q       <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      fd_instr_q       <= fd_instr_d;
      fd_pc_q          <= fd_pc_d;
      fd_pc_plus_one_q <= fd_pc_plus_one_d;
      fd_valid_q       <= fd_valid_d;
    end
  end

  // imem address is the truncated PC, combinational from the register.
  assign bus.address_imem   = pc_q[ADDR_W-1:0];
  assign bus.pc             = pc_q;
  assign bus.fd_instr       = fd_instr_q;
  assign bus.fd_pc          = fd_pc_q;
  assign bus.fd_pc_plus_one = fd_pc_plus_one_q;
  assign bus.fd_valid       = fd_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Counters observe the same edge decision as the datapath; both wrap.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (bus.redirect || bus.stall) perf_bubbles_d = perf_bubbles_q + 32'd1;
    else                           perf_fetched_d = perf_fetched_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clock = 1'b0;
  logic reset;

  fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_stage #(
    .ADDR_W(ADDR_W),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Synchronous imem on the inverted clock.
  logic [31:0] imem [0:DEPTH-1];
  always @(negedge clock) bus.q_imem = imem[bus.address_imem];

  // Reference model state (plain arithmetic over the fetch rules).
  logic [31:0] m_pc, m_instr, m_fpc, m_fpp1, m_fet, m_bub;
  logic        m_valid;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("pc",       bus.pc, m_pc);
    chk("addr",     32'(bus.address_imem), m_pc % DEPTH);
    chk("fd_valid", 32'(bus.fd_valid), 32'(m_valid));
    chk("fd_instr", bus.fd_instr, m_instr);
    chk("fd_pc",    bus.fd_pc, m_fpc);
    chk("fd_pc1",   bus.fd_pc_plus_one, m_fpp1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", bus.perf_fetched, m_fet);
    chk("perf_bubbles", bus.perf_bubbles, m_bub);
`endif
  endtask

  // One rising edge with the given controls, then model update and compare.
  task automatic step(input logic rst_n, input logic st, input logic rd, input logic [31:0] tgt);
    reset         = rst_n;
    bus.stall     = st;
    bus.redirect  = rd;
    bus.target_pc = tgt;
    @(posedge clock);
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_fpc = 32'h0; m_fpp1 = 32'h0; m_valid = 1'b0;
      m_fet = 32'h0; m_bub = 32'h0;
    end else if (rd) begin
      m_pc = tgt; m_instr = 32'h0; m_fpc = 32'h0; m_fpp1 = 32'h0; m_valid = 1'b0;
      m_bub = m_bub + 1;
    end else if (st) begin
      m_bub = m_bub + 1;
    end else begin
      m_instr = imem[m_pc % DEPTH];
      m_fpc   = m_pc;
      m_fpp1  = m_pc + 1;
      m_valid = 1'b1;
      m_pc    = m_pc + 1;
      m_fet   = m_fet + 1;
    end
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] tgt;
    int          sel;
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
    imem[0] = 32'hA0; imem[1] = 32'hA1; imem[2] = 32'hA2; imem[3] = 32'hA3;

    // Reset dominates stall and redirect.
    step(1'b0, 1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_valid", 32'(bus.fd_valid), 32'h0);

    // Sequential fetch.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("seq_first", bus.fd_instr, 32'hA0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Stall at pc=2 for 3 cycles, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_hold", bus.fd_instr, 32'hA1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_rel_pc", bus.pc, 32'h3);

    // Redirect beats stall.
    step(1'b1, 1'b1, 1'b1, 32'h10);
    chk("redir_pc", bus.pc, 32'h10);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Address wrap and PC arithmetic wrap.
    step(1'b1, 1'b0, 1'b1, 32'hFFF);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr0", 32'(bus.address_imem), 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_fdpc", bus.fd_pc, 32'h1000);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc1", bus.fd_pc_plus_one, 32'h0);

    // Back-to-back redirects, including redirect to the current pc.
    step(1'b1, 1'b0, 1'b1, 32'h20);
    step(1'b1, 1'b0, 1'b1, 32'h20);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Randomized traffic with occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: tgt = m_pc;
        1: tgt = 32'hFFE;
        2: tgt = 32'hFFFF_FFFE;
        default: tgt = $urandom;
      endcase
      step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 10, tgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end sitting directly upstream of the decode stage of the 5-stage processor.
- Owns the program counter and drives the word address into the synchronous imem; imem is clocked on the inverted clock.
- Captures the returned instruction into the F/D pipeline register.
- Honours decode-stage stalls and execute-stage branch/jump redirects; redirects insert a bubble.

Parameters:
- ADDR_W, 12, width of imem word address (address = pc[ADDR_W-1:0]).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected on reset and flush.

Ports:
- clock  in  1  master clock, rising-edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  decode hazard; hold PC and F/D register.
- redirect  in  1  taken branch/jump from execute.
- target_pc  in  32  redirect destination (word address).
- q_imem  in  32  instruction word from imem for the current address_imem.
- address_imem  out  ADDR_W  imem word address; equals pc[ADDR_W-1:0].
- pc  out  32  current fetch PC.
- fd_instr  out  32  F/D instruction register.
- fd_pc  out  32  PC of fd_instr.
- fd_pc_plus_one  out  32  fd_pc + 1, registered.
- fd_valid  out  1  fd_instr is a real fetched instruction (0 = bubble).

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-low (reset). All state updates on the rising edge of clock.
- Word addressing: PC advances by 1 per instruction, not by 4.
- Imem timing:
  - address_imem is combinational from the pc register.
  - imem samples on the falling edge, so q_imem is valid before the next rising edge.
  - Fetch latency is one cycle: the instruction at pc appears on fd_instr after the next rising edge.
- Reset (reset==0 at a rising edge):
  - pc<=RESET_PC; fd_instr<=NOP_INSTR; fd_pc<=0; fd_pc_plus_one<=0; fd_valid<=0.
  - Performance counters (if compiled in) are cleared.
  - reset overrides stall and redirect.
  - Reset mid-operation discards any in-flight instruction; there is no partial update.
- Priority per edge (reset deasserted): redirect > stall > normal.
  - Normal (redirect=0, stall=0): fd_instr<=q_imem; fd_pc<=pc; fd_pc_plus_one<=pc+1; fd_valid<=1; pc<=pc+1.
  - Stall (redirect=0, stall=1): pc and all fd_* hold. address_imem is unchanged, so q_imem stays stable; no skid storage is needed.
  - Redirect (redirect=1, stall ignored): pc<=target_pc; fd_instr<=NOP_INSTR; fd_pc<=0; fd_pc_plus_one<=0; fd_valid<=0. The wrong-path instruction in flight is discarded.
  - Redirect with target_pc == pc is legal and behaves identically to any other redirect (bubble, then refetch).
- Back-to-back redirects: each one reloads pc and keeps fd_valid=0. No instruction is emitted until a cycle with redirect=0.
- Stall during a bubble: the bubble (fd_valid=0) is held.
- Arithmetic: pc+1 is 32-bit modulo; 32'hFFFF_FFFF+1 = 0.
- Address wrap: address_imem is the truncation of pc. pc=4095 gives address 4095; pc=4096 gives address 0 while pc reads 4096.
- Outputs never go X after the first reset edge. q_imem is not sampled during reset.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_bubbles (32), both reset to 0.
  - perf_fetched increments on every normal-update edge.
  - perf_bubbles increments on every redirect edge and every stall edge.
  - Both counters wrap modulo 2^32.
  - Counters do not affect datapath timing.
- Undefined: the ports and counters are absent; the module is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with stall=1, redirect=1, target_pc=0x40 -> pc=0, fd_valid=0, fd_instr=0, address_imem=0.
- Sequential fetch: imem[0..3]=0xA0,0xA1,0xA2,0xA3, no stall/redirect -> over 4 edges fd_instr=0xA0..0xA3, fd_pc=0..3, fd_pc_plus_one=1..4, fd_valid=1, final pc=4.
- Stall: stall=1 for 3 cycles at pc=2 -> pc=2 and fd_instr=0xA1 held for all 3 cycles. After release, fd_instr=0xA2, pc=3.
- Redirect priority: redirect=1, stall=1, target_pc=0x10 at pc=3 -> next cycle pc=0x10, fd_valid=0, fd_instr=NOP. Following edge: fd_instr=imem[0x10], fd_pc=0x10.
- Wrap: redirect to target_pc=0xFFF, run 2 edges -> fd_pc=0xFFF then 0x1000, address_imem=0xFFF then 0x000; separately target_pc=0xFFFF_FFFF -> fd_pc_plus_one=0.
- FETCH_PERF_EN: 5 normal edges, 2 stall edges, 1 redirect edge -> perf_fetched=5, perf_bubbles=3. Mid-run reset -> both counters 0.
